// File: rtl/data_mem_copier.sv
// Block-copy initiator for the data-memory port: reads LEN words from a source
// index and writes them to a destination index, one read/write pair per word.
module data_mem_copier #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_src,
  input  logic [ADDR_W-1:0]     i_dst,
  input  logic [DEPTH_LOG2:0]   i_len,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [1:0]            o_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state;
  logic [DEPTH_LOG2-1:0] src_q;
  logic [DEPTH_LOG2-1:0] dst_q;
  logic [DEPTH_LOG2:0]   len_q;
  logic [DEPTH_LOG2:0]   idx_q;
  logic [DATA_W-1:0]     hold_q;

  logic [DEPTH_LOG2-1:0] src_addr;
  logic [DEPTH_LOG2-1:0] dst_addr;
  logic [DEPTH_LOG2:0]   idx_next;
  logic                  last_word;
  logic                  unused_addr_bits;

  // Only the low DEPTH_LOG2 bits of the indices matter; the sums wrap naturally.
  assign unused_addr_bits = ^{i_src[ADDR_W-1:DEPTH_LOG2], i_dst[ADDR_W-1:DEPTH_LOG2]};
  assign src_addr  = src_q + idx_q[DEPTH_LOG2-1:0];
  assign dst_addr  = dst_q + idx_q[DEPTH_LOG2-1:0];
  assign idx_next  = idx_q + (DEPTH_LOG2+1)'(1);
  assign last_word = (idx_next == len_q);

  // Handshake: i_start is a level sampled only in IDLE; there is no ready,
  // so a start seen in RD/WR/DONE is dropped rather than queued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      hold_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            src_q <= i_src[DEPTH_LOG2-1:0];
            dst_q <= i_dst[DEPTH_LOG2-1:0];
            len_q <= i_len;
            idx_q <= '0;
            state <= (i_len == '0) ? ST_DONE : ST_RD;
          end
        end
        ST_RD: begin
          hold_q <= i_mem_rdata;
          state  <= ST_WR;
        end
        ST_WR: begin
          idx_q <= idx_next;
          state <= last_word ? ST_DONE : ST_RD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_wdata = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state)
      ST_RD: begin
        o_mem_addr = ADDR_W'(src_addr);
        o_mem_read = 1'b1;
        o_busy     = 1'b1;
      end
      ST_WR: begin
        o_mem_addr  = ADDR_W'(dst_addr);
        o_mem_write = 1'b1;
        o_mem_wdata = hold_q;
        o_busy      = 1'b1;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_count = idx_q;
  assign o_state = state;

  a_rd_wr_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_mem_read && o_mem_write));
  a_done_one_cycle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_done |=> !o_done);

endmodule

// File: tb/tb_data_mem_copier.sv
// Self-checking bench for data_mem_copier: a behavioural copy model predicts
// every cycle's port values and the final memory image.
module tb_data_mem_copier;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_src;
  logic [31:0] i_dst;
  logic [8:0]  i_len;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_mem_addr;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] o_mem_wdata;
  logic        o_busy;
  logic        o_done;
  logic [8:0]  o_count;
  logic [1:0]  o_state;

  data_mem_copier dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_src(i_src), .i_dst(i_dst), .i_len(i_len),
    .i_mem_rdata(i_mem_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_count(o_count), .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- memory and counters ----------------
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  assign i_mem_rdata = o_mem_read ? mem[o_mem_addr[7:0]] : 32'h0;

  always @(posedge i_clk) begin
    if (i_rst_n && o_mem_write) begin
      mem[o_mem_addr[7:0]] = o_mem_wdata;
      wr_cnt++;
    end
    if (i_rst_n && o_mem_read) rd_cnt++;
  end

  always @(negedge i_clk) if (o_done) done_cnt++;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [8:0]  count;
  } exp_t;

  exp_t exp_q[$];
  logic [8:0] model_count = '0;
  bit checking = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 60)
        $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [31:0] wdata, input logic busy, input logic done,
                              input logic [8:0] count);
    exp_t e;
    e.addr = addr; e.rd = rd; e.wr = wr; e.wdata = wdata;
    e.busy = busy; e.done = done; e.count = count;
    return e;
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (checking && i_rst_n) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, model_count);
      check("addr",  64'(o_mem_addr),  64'(e.addr));
      check("read",  64'(o_mem_read),  64'(e.rd));
      check("write", 64'(o_mem_write), 64'(e.wr));
      check("wdata", 64'(o_mem_wdata), 64'(e.wdata));
      check("busy",  64'(o_busy),      64'(e.busy));
      check("done",  64'(o_done),      64'(e.done));
      check("count", 64'(o_count),     64'(e.count));
      check("rd_wr_exclusive", 64'(o_mem_read && o_mem_write), 64'(0));
      if (e.wr) ref_mem[e.addr[7:0]] = e.wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  // Issues a start from IDLE and predicts the full cycle trace of the copy:
  // per word one read cycle then one write cycle, then one done cycle.
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] tmp [256];
    logic [7:0]  sa;
    logic [7:0]  da;
    logic [31:0] w;
    @(posedge i_clk); #1;
    i_start = 1'b1; i_src = src; i_dst = dst; i_len = 9'(len);
    @(posedge i_clk); #1;
    i_start = 1'b0; i_src = $urandom; i_dst = $urandom; i_len = 9'($urandom);
    tmp = ref_mem;
    for (int k = 0; k < len; k++) begin
      sa = src[7:0] + 8'(k);
      da = dst[7:0] + 8'(k);
      w = tmp[sa];
      tmp[da] = w;
      exp_q.push_back(mk(32'(sa), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 9'(k)));
      exp_q.push_back(mk(32'(da), 1'b0, 1'b1, w,     1'b1, 1'b0, 9'(k)));
    end
    exp_q.push_back(mk(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 9'(len)));
    model_count = 9'(len);
  endtask

  // Returns the cycle number (1 = cycle right after the start edge) of o_done.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge i_clk);
      cyc++;
    end while (!o_done && cyc < 600);
    check("done_seen_within_budget", 64'(o_done), 64'(1));
  endtask

  task automatic check_mem(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    check(name, 64'(bad), 64'(0));
    if (bad != 0) $display("  first differing word index %0d", first);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_addr"},  64'(o_mem_addr),  64'(0));
    check({name, "_read"},  64'(o_mem_read),  64'(0));
    check({name, "_write"}, 64'(o_mem_write), 64'(0));
    check({name, "_wdata"}, 64'(o_mem_wdata), 64'(0));
    check({name, "_busy"},  64'(o_busy),      64'(0));
    check({name, "_done"},  64'(o_done),      64'(0));
    check({name, "_count"}, 64'(o_count),     64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int w0;
    int r0;
    int d0;
    int len;
    i_rst_n = 1'b0; i_start = 1'b0; i_src = '0; i_dst = '0; i_len = '0;
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    @(posedge i_clk); #1;
    check_idle_outputs("reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    checking = 1'b1;

    // basic copy
    poke(2, 32'h3F); poke(3, 32'h09); poke(4, 32'h07);
    w0 = wr_cnt;
    start_copy(32'd2, 32'd20, 3);
    wait_done(cyc);
    check("basic_done_cycle", 64'(cyc), 64'(7));
    check("basic_count", 64'(o_count), 64'(3));
    @(posedge i_clk); #1;
    check("basic_write_strobes", 64'(wr_cnt - w0), 64'(3));
    check("basic_mem20", 64'(mem[20]), 64'h3F);
    check("basic_mem21", 64'(mem[21]), 64'h09);
    check("basic_mem22", 64'(mem[22]), 64'h07);
    check_mem("basic_image");

    // zero length
    w0 = wr_cnt; r0 = rd_cnt;
    start_copy(32'd77, 32'd88, 0);
    wait_done(cyc);
    check("len0_done_cycle", 64'(cyc), 64'(1));
    check("len0_count", 64'(o_count), 64'(0));
    @(posedge i_clk); #1;
    check("len0_write_strobes", 64'(wr_cnt - w0), 64'(0));
    check("len0_read_strobes", 64'(rd_cnt - r0), 64'(0));

    // address wrap on the source side
    poke(254, 32'hAAAA_000A); poke(255, 32'hBBBB_000B);
    poke(0, 32'hCCCC_000C);   poke(1, 32'hDDDD_000D);
    start_copy(32'd254, 32'd9, 4);
    wait_done(cyc);
    check("wrap_done_cycle", 64'(cyc), 64'(9));
    @(posedge i_clk); #1;
    check("wrap_mem9",  64'(mem[9]),  64'hAAAA_000A);
    check("wrap_mem10", 64'(mem[10]), 64'hBBBB_000B);
    check("wrap_mem11", 64'(mem[11]), 64'hCCCC_000C);
    check("wrap_mem12", 64'(mem[12]), 64'hDDDD_000D);

    // overlapping forward copy smears the first word
    poke(0, 32'd1); poke(1, 32'd2); poke(2, 32'd3); poke(3, 32'd4);
    start_copy(32'd0, 32'd1, 3);
    wait_done(cyc);
    @(posedge i_clk); #1;
    check("overlap_mem1", 64'(mem[1]), 64'd1);
    check("overlap_mem2", 64'(mem[2]), 64'd1);
    check("overlap_mem3", 64'(mem[3]), 64'd1);
    check_mem("overlap_image");

    // start pulses while busy and while in DONE are ignored
    for (int k = 0; k < 6; k++) poke(30 + k, 32'h5555_0000 + 32'(k));
    d0 = done_cnt;
    start_copy(32'd30, 32'd60, 6);
    repeat (3) @(posedge i_clk);
    #1;
    i_start = 1'b1; i_src = 32'd5; i_dst = 32'd6; i_len = 9'd9;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(cyc);
    i_start = 1'b1; i_src = 32'd7; i_dst = 32'd8; i_len = 9'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check("ignored_start_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("ignored_start_busy", 64'(o_busy), 64'(0));
    check("ignored_start_mem60", 64'(mem[60]), 64'h5555_0000);
    check("ignored_start_mem65", 64'(mem[65]), 64'h5555_0005);
    check_mem("ignored_start_image");

    // reset after the second write aborts the copy
    for (int k = 0; k < 5; k++) begin
      poke(40 + k, 32'hC000_0000 + 32'(k));
      poke(100 + k, 32'hD000_0000 + 32'(k));
    end
    start_copy(32'd40, 32'd100, 5);
    repeat (4) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    model_count = '0;
    #1;
    check_idle_outputs("abort");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check("abort_mem100", 64'(mem[100]), 64'hC000_0000);
    check("abort_mem101", 64'(mem[101]), 64'hC000_0001);
    check("abort_mem102", 64'(mem[102]), 64'hD000_0002);
    check("abort_mem104", 64'(mem[104]), 64'hD000_0004);
    check_mem("abort_image");
    start_copy(32'd40, 32'd100, 5);
    wait_done(cyc);
    check("restart_done_cycle", 64'(cyc), 64'(11));
    @(posedge i_clk); #1;
    check("restart_mem104", 64'(mem[104]), 64'hC000_0004);

    // randomized copies, including full-depth and zero length
    for (int t = 0; t < 12; t++) begin
      for (int j = 0; j < 8; j++) poke($urandom_range(0, 255), $urandom);
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = 256;
        default: len = $urandom_range(1, 40);
      endcase
      repeat ($urandom_range(0, 3)) @(posedge i_clk);
      start_copy($urandom, $urandom, len);
      wait_done(cyc);
      check("rand_done_cycle", 64'(cyc), 64'(2 * len + 1));
      @(posedge i_clk); #1;
      check_mem("rand_image");
    end

    repeat (3) @(posedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog actual=running required=finished time=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_copier.md
# data_mem_copier

Block-copy initiator for the data-memory port. On a start pulse it reads `LEN` consecutive words from a source word index and writes them to a destination word index, one word at a time. It drives the memory's address, read-enable, write-enable and write-data pins directly. It sits beside the datapath's load/store path and owns the memory port only while busy; the top-level mux selects it via `o_busy`.

## Interface
Parameters:
- `DATA_W`, 32, word width, matching the memory word.
- `ADDR_W`, 32, width of the memory address bus.
- `DEPTH_LOG2`, 8, log2 of memory depth (256 words); all generated addresses are taken modulo 2^DEPTH_LOG2.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_src`  in  ADDR_W  source word index; captured at start.
- `i_dst`  in  ADDR_W  destination word index; captured at start.
- `i_len`  in  DEPTH_LOG2+1  word count, 0..256; captured at start.
- `i_mem_rdata`  in  DATA_W  memory read data (combinational from `o_mem_addr` when `o_mem_read`=1).
- `o_mem_addr`  out  ADDR_W  memory address; upper ADDR_W-DEPTH_LOG2 bits are always 0.
- `o_mem_read`  out  1  memory read enable.
- `o_mem_write`  out  1  memory write enable (memory writes on the rising edge).
- `o_mem_wdata`  out  DATA_W  memory write data.
- `o_busy`  out  1  high in RD and WR states.
- `o_done`  out  1  one-cycle completion pulse.
- `o_count`  out  DEPTH_LOG2+1  words written so far in the current or last copy.

## Operation
- States: IDLE, RD, WR, DONE. Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- **IDLE:**
  - All memory outputs are 0.
  - When `i_start`=1, capture src, dst and len, and clear idx and `o_count`.
  - If len=0, go to DONE; otherwise go to RD.
- **RD:**
  - `o_mem_addr` = (src+idx) mod 2^DEPTH_LOG2, `o_mem_read`=1.
  - At the edge, latch `i_mem_rdata` into the hold register and go to WR.
- **WR:**
  - `o_mem_addr` = (dst+idx) mod 2^DEPTH_LOG2, `o_mem_write`=1, `o_mem_wdata` = hold register.
  - At the edge, idx and `o_count` increment.
  - If idx+1 == len, go to DONE; else go to RD.
- **DONE:** `o_done`=1 for exactly one cycle, then go to IDLE. `o_count` holds its value until the next start.
- Copy order is strictly ascending idx.
  - For overlapping ranges with dst > src, later reads see already-written words. This is defined behaviour, not an error.
  - src == dst rewrites each word with itself.
- `i_start` while busy or in DONE is ignored; no queuing.
- Changes to `i_src`, `i_dst` or `i_len` after capture have no effect.
- Address wrap: index 255+1 → 0 on both the source and destination sides.
- Counters are DEPTH_LOG2+1 bits so that len=256 terminates correctly.

## Timing
- Reset (async, `i_rst_n`=0): state=IDLE. `o_mem_addr`=0, `o_mem_read`=0, `o_mem_write`=0, `o_mem_wdata`=0, `o_busy`=0, `o_done`=0, `o_count`=0, hold register=0.
- Reset asserted mid-copy aborts immediately. Words already written stay written, and no further write occurs after reset assertion.
- Start accepted at edge T0:
  - RD is occupied during cycle T0..T1.
  - Word k is read in cycle 2k+1 and written at the edge ending cycle 2k+2.
  - `o_done` is high during cycle 2·len+1 after T0.
  - Busy lasts 2·len cycles.
- len=0: `o_done` is high in the cycle right after the start edge, with no memory access.
- `o_mem_read` and `o_mem_write` are never high in the same cycle.
- Earliest restart: `i_start` sampled in the cycle after DONE, i.e. back in IDLE.

## Test plan
- Preload mem[2..4]=0x3F,0x09,0x07; start src=2, dst=20, len=3 → mem[20..22]=0x3F,0x09,0x07; `o_done` pulses 7 cycles after start; `o_count`=3; write strobes appear on exactly 3 cycles.
- Start with len=0 → `o_done` in the next cycle; `o_mem_read` and `o_mem_write` never asserted; `o_count`=0.
- Start src=254, dst=9, len=4, mem[254,255,0,1]=A,B,C,D → mem[9..12]=A,B,C,D; addresses observed are 254,255,0,1.
- Overlap: mem[0..3]=1,2,3,4; src=0, dst=1, len=3 → mem[1..3]=1,1,1.
- `i_start` pulsed mid-copy with different src/dst/len → ignored; the original copy completes unchanged; one `o_done`.
- Assert `i_rst_n`=0 after the second write of a len=5 copy → all outputs 0 asynchronously; only 2 destination words are modified; a fresh start after release works normally.
